// File: rtl/clock_set_controller_pkg.sv
// Shared mode encodings, BCD field limits and the BCD increment helper for the
// HH:MM:SS board clock.
package clock_set_controller_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    // Field limits are stored as packed BCD (tens in [7:4], units in [3:0]).
    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] MN_MAX = 8'h59;
    localparam logic [7:0] SC_MAX = 8'h59;

    function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] limit);
        if (value == limit) return 8'h00;
        if (value[3:0] == 4'd9) return {value[7:4] + 4'd1, 4'd0};
        return {value[7:4], value[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/clock_set_controller_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-level filter and a
// one-cycle pulse on the accepted press (debounced 1->0) edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_btn;
    logic          level;
    logic [CW-1:0] cnt;

    // NOTE: every flop here uses <= so all of them sample the pre-edge values,
    // which is what makes the synchronizer a real two-stage pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_btn  <= 1'b1;
            level     <= 1'b1;
            cnt       <= '0;
            press     <= 1'b0;
        end else begin
            sync_meta <= btn_n;
            sync_btn  <= sync_meta;
            press     <= 1'b0;
            if (sync_btn == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_btn;
                cnt   <= '0;
                press <= !sync_btn;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// 24 h HH:MM:SS timekeeper with RUN / SET_HR / SET_MIN sequencer, 1 Hz
// prescaler and 2 Hz blink of the field being set.
module clock_set_controller
    import clock_set_controller_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode_n,
    input  logic       btn_inc_n,
    output logic [3:0] hr_t,
    output logic [3:0] hr_u,
    output logic [3:0] mn_t,
    output logic [3:0] mn_u,
    output logic [3:0] sc_t,
    output logic [3:0] sc_u,
    output logic [5:0] digit_blank,
    output logic [1:0] mode
);

    localparam int BLINK_CYCLES = (CLK_HZ / 4 > 1) ? CLK_HZ / 4 : 1;
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic          mode_press;
    logic          inc_press;
    logic          inc_accept;
    logic          tick;
    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    mode_e         state;
    logic [7:0]    hr, mn, sc;
    logic [7:0]    hr_adv, mn_adv, sc_adv;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_mode_n),
        .press (mode_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_inc_n),
        .press (inc_press)
    );

    // Full seconds->minutes->hours ripple resolved in one cycle.
    assign tick       = (presc == PRESC_LAST);
    assign sc_adv     = bcd_inc(sc, SC_MAX);
    assign mn_adv     = (sc == SC_MAX) ? bcd_inc(mn, MN_MAX) : mn;
    assign hr_adv     = (sc == SC_MAX && mn == MN_MAX) ? bcd_inc(hr, HR_MAX) : hr;
    assign inc_accept = inc_press && !mode_press && (state != MODE_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MODE_RUN;
            hr          <= 8'h00;
            mn          <= 8'h00;
            sc          <= 8'h00;
            presc       <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);

            if (mode_press || inc_accept) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            if (mode_press) begin
                case (state)
                    MODE_RUN: begin
                        state <= MODE_SET_HR;
                        if (tick) begin
                            hr <= hr_adv;
                            mn <= mn_adv;
                            sc <= sc_adv;
                        end
                    end
                    MODE_SET_HR: state <= MODE_SET_MIN;
                    MODE_SET_MIN: begin
                        // Restart the second so the first tick is a full period away.
                        state <= MODE_RUN;
                        sc    <= 8'h00;
                        presc <= '0;
                    end
                    default: state <= MODE_RUN;
                endcase
            end else begin
                case (state)
                    MODE_RUN: begin
                        if (tick) begin
                            hr <= hr_adv;
                            mn <= mn_adv;
                            sc <= sc_adv;
                        end
                    end
                    MODE_SET_HR:  if (inc_press) hr <= bcd_inc(hr, HR_MAX);
                    MODE_SET_MIN: if (inc_press) mn <= bcd_inc(mn, MN_MAX);
                    default:      state <= MODE_RUN;
                endcase
            end
        end
    end

    // NOTE: digit_blank gets its default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        digit_blank = 6'b000000;
        if (blink_phase) begin
            case (state)
                MODE_SET_HR:  digit_blank = 6'b110000;
                MODE_SET_MIN: digit_blank = 6'b001100;
                default:      digit_blank = 6'b000000;
            endcase
        end
    end

    assign mode = state;
    assign hr_t = hr[7:4];
    assign hr_u = hr[3:0];
    assign mn_t = mn[7:4];
    assign mn_u = mn[3:0];
    assign sc_t = sc[7:4];
    assign sc_u = sc[3:0];

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: time-of-day model compared every cycle, plus
// literal expectations for reset, run, wrap, set, bounce, exit and simultaneity.
module tb_clock_set_controller;

    localparam int CLK_HZ = 8;
    localparam int DEB    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode_n = 1'b1;
    logic       btn_inc_n = 1'b1;
    logic [3:0] hr_t, hr_u, mn_t, mn_u, sc_t, sc_u;
    logic [5:0] digit_blank;
    logic [1:0] mode;
    logic [31:0] outs;

    int checks = 0;
    int errors = 0;

    clock_set_controller #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_mode_n  (btn_mode_n),
        .btn_inc_n   (btn_inc_n),
        .hr_t        (hr_t),
        .hr_u        (hr_u),
        .mn_t        (mn_t),
        .mn_u        (mn_u),
        .sc_t        (sc_t),
        .sc_u        (sc_u),
        .digit_blank (digit_blank),
        .mode        (mode)
    );

    assign outs = {hr_t, hr_u, mn_t, mn_u, sc_t, sc_u, digit_blank, mode};

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit d1;
        bit d2;
        bit run_val;
        int run_len;
        bit level;
    } btn_model_t;

    btn_model_t bm_mode, bm_inc;
    int  m_hr, m_mn, m_sc, m_mode;
    int  edge_n, presc_org, blink_org;
    bit  mode_pend, inc_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hr = 0; m_mn = 0; m_sc = 0; m_mode = 0;
        edge_n = 0; presc_org = 0; blink_org = 0;
        mode_pend = 1'b0; inc_pend = 1'b0;
        bm_mode = '{d1: 1'b1, d2: 1'b1, run_val: 1'b1, run_len: 0, level: 1'b1};
        bm_inc  = '{d1: 1'b1, d2: 1'b1, run_val: 1'b1, run_len: 0, level: 1'b1};
    endtask

    // Button level accepted after DEB identical samples, seen two cycles late.
    function automatic btn_model_t btn_next(input btn_model_t s, input bit raw);
        btn_model_t n = s;
        bit eff = s.d2;
        n.d2 = s.d1;
        n.d1 = raw;
        if (eff == s.run_val) n.run_len = s.run_len + 1;
        else begin
            n.run_val = eff;
            n.run_len = 1;
        end
        if (n.run_len >= DEB && n.run_val != s.level) n.level = n.run_val;
        return n;
    endfunction

    task automatic advance_second();
        int t = (m_hr * 3600 + m_mn * 60 + m_sc + 1) % 86400;
        m_hr = t / 3600;
        m_mn = (t / 60) % 60;
        m_sc = t % 60;
    endtask

    task automatic model_step();
        bit mp, ip, tick;
        btn_model_t nx;
        mp = mode_pend;
        ip = inc_pend;
        edge_n++;
        tick = ((edge_n - presc_org) % CLK_HZ) == 0;
        if (mp) begin
            blink_org = edge_n;
            case (m_mode)
                0: begin
                    if (tick) advance_second();
                    m_mode = 1;
                end
                1: m_mode = 2;
                default: begin
                    m_mode = 0;
                    m_sc = 0;
                    presc_org = edge_n;
                end
            endcase
        end else if (m_mode == 0) begin
            if (tick) advance_second();
        end else if (ip) begin
            blink_org = edge_n;
            if (m_mode == 1) m_hr = (m_hr + 1) % 24;
            else m_mn = (m_mn + 1) % 60;
        end
        nx = btn_next(bm_mode, btn_mode_n);
        mode_pend = bm_mode.level && !nx.level;
        bm_mode = nx;
        nx = btn_next(bm_inc, btn_inc_n);
        inc_pend = bm_inc.level && !nx.level;
        bm_inc = nx;
    endtask

    function automatic logic [31:0] model_vec();
        int phase = ((edge_n - blink_org) / (CLK_HZ / 4)) % 2;
        logic [5:0] blank = 6'b000000;
        if (phase == 1 && m_mode == 1) blank = 6'b110000;
        if (phase == 1 && m_mode == 2) blank = 6'b001100;
        return {4'(m_hr / 10), 4'(m_hr % 10), 4'(m_mn / 10), 4'(m_mn % 10),
                4'(m_sc / 10), 4'(m_sc % 10), blank, 2'(m_mode)};
    endfunction

    initial model_reset();

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (rst_n) check("cycle", outs, model_vec());
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input bit m, input bit i, input int hold);
        @(negedge clk);
        if (m) btn_mode_n = 1'b0;
        if (i) btn_inc_n = 1'b0;
        repeat (hold) @(negedge clk);
        btn_mode_n = 1'b1;
        btn_inc_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_edge(input int target);
        int guard = 0;
        while (edge_n < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n != target) begin
            errors++;
            $display("FAIL wait_edge: reached edge %0d, wanted %0d", edge_n, target);
        end
    endtask

    task automatic mid_cycle_reset(input string name);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check(name, outs, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int org, w, n, tr;
        logic [1:0] prev;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Run: one minute of ticks.
        wait_edge(480);
        check("run_1min", outs, {24'h000100, 6'b0, 2'd0});

        // Asynchronous reset mid-cycle.
        mid_cycle_reset("reset_run");

        // Wrap: set 23:59, then run through midnight.
        press(1'b1, 1'b0, 4);
        n = (23 - m_hr + 24) % 24;
        for (int k = 0; k < n; k++) press(1'b0, 1'b1, 4);
        press(1'b1, 1'b0, 4);
        n = (59 - m_mn + 60) % 60;
        for (int k = 0; k < n; k++) press(1'b0, 1'b1, 4);
        press(1'b1, 1'b0, 4);
        org = presc_org;
        check("set_2359", {outs[31:8], mode}, {24'h235900, 2'd0});
        wait_edge(org + 59 * CLK_HZ);
        check("wrap_235959", {outs[31:8], mode}, {24'h235959, 2'd0});
        wait_edge(org + 60 * CLK_HZ);
        check("wrap_000000", outs, 32'h0);
        w = org + 60 * CLK_HZ;

        // Mode press landing on a tick: advance applies and SET_HR is entered.
        wait_edge(w + 5 * CLK_HZ - 8);
        press(1'b1, 1'b0, 4);
        check("tick_and_mode", {outs[31:8], mode}, {24'h000005, 2'd1});

        // Set hours: 25 presses wrap past 23.
        for (int k = 0; k < 25; k++) press(1'b0, 1'b1, 4);
        check("set_hr_25", {outs[31:8], mode}, {24'h010005, 2'd1});
        tr = 0;
        prev = digit_blank[5:4];
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check("blank_lo", {26'h0, digit_blank[3:0]}, 32'h0);
            check("blank_hi_pair", {31'h0, (digit_blank[5:4] == 2'b00 || digit_blank[5:4] == 2'b11)}, 32'h1);
            if (digit_blank[5:4] != prev) tr++;
            prev = digit_blank[5:4];
        end
        check("blink_rate", {31'h0, (tr == 49 || tr == 50)}, 32'h1);
        check("frozen", {outs[31:8], mode}, {24'h010005, 2'd1});

        // Bounce: a 3-cycle glitch is ignored, a 4-cycle press counts once.
        press(1'b0, 1'b1, 3);
        check("glitch", {outs[31:8], mode}, {24'h010005, 2'd1});
        press(1'b0, 1'b1, 4);
        check("clean_press", {outs[31:8], mode}, {24'h020005, 2'd1});

        // Exit SET_MIN: seconds cleared, prescaler restarted.
        press(1'b1, 1'b0, 4);
        check("to_set_min", {outs[31:8], mode}, {24'h020005, 2'd2});
        press(1'b1, 1'b0, 4);
        org = presc_org;
        check("exit_sc0", {outs[31:8], mode}, {24'h020000, 2'd0});
        wait_edge(org + CLK_HZ - 1);
        check("pre_first_tick", {outs[31:8], mode}, {24'h020000, 2'd0});
        wait_edge(org + CLK_HZ);
        check("first_tick", {outs[31:8], mode}, {24'h020001, 2'd0});

        // Hold sc=37, edit, then mode+inc together: mode wins.
        wait_edge(org + 37 * CLK_HZ - 2);
        press(1'b1, 1'b0, 4);
        check("hold_37", {outs[31:8], mode}, {24'h020037, 2'd1});
        press(1'b0, 1'b1, 4);
        check("hr_inc", {outs[31:8], mode}, {24'h030037, 2'd1});
        press(1'b1, 1'b0, 4);
        press(1'b0, 1'b1, 4);
        check("mn_inc", {outs[31:8], mode}, {24'h030137, 2'd2});
        press(1'b1, 1'b1, 4);
        check("mode_beats_inc", {outs[31:8], mode}, {24'h030100, 2'd0});
        press(1'b0, 1'b1, 4);
        check("inc_in_run", {outs[31:16], mode}, {16'h0301, 2'd0});

        // Reset while in SET_MIN.
        press(1'b1, 1'b0, 4);
        press(1'b1, 1'b0, 4);
        check("in_set_min", {30'h0, mode}, 32'd2);
        mid_cycle_reset("reset_set_min");

        // Randomized presses and glitches against the model.
        for (int k = 0; k < 40; k++) begin
            int r = $urandom_range(0, 9);
            int hold = $urandom_range(1, 6);
            press(r < 2, r >= 1, hold);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
